// File: rtl/alu_pkg.sv
// Shared types and canonical control words for the pipelined Hack-style ALU.
// Control bit order, MSB first: zx, nx, zy, ny, f, no.
package alu_pkg;

  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_ctrl_t;

  localparam alu_ctrl_t ALU_ZERO  = 6'b101010;
  localparam alu_ctrl_t ALU_ONE   = 6'b111111;
  localparam alu_ctrl_t ALU_NEG1  = 6'b111010;
  localparam alu_ctrl_t ALU_X     = 6'b001100;
  localparam alu_ctrl_t ALU_Y     = 6'b110000;
  localparam alu_ctrl_t ALU_NOTX  = 6'b001101;
  localparam alu_ctrl_t ALU_NOTY  = 6'b110001;
  localparam alu_ctrl_t ALU_NEGX  = 6'b001111;
  localparam alu_ctrl_t ALU_NEGY  = 6'b110011;
  localparam alu_ctrl_t ALU_XP1   = 6'b011111;
  localparam alu_ctrl_t ALU_YP1   = 6'b110111;
  localparam alu_ctrl_t ALU_XM1   = 6'b001110;
  localparam alu_ctrl_t ALU_YM1   = 6'b110010;
  localparam alu_ctrl_t ALU_XPY   = 6'b000010;
  localparam alu_ctrl_t ALU_XMY   = 6'b010011;
  localparam alu_ctrl_t ALU_YMX   = 6'b000111;
  localparam alu_ctrl_t ALU_XANDY = 6'b000000;
  localparam alu_ctrl_t ALU_XORY  = 6'b010101;

endpackage

// File: rtl/alu_core.sv
// Combinational function/output stage of the Hack-style ALU operating on preset operands.
// Carry and overflow describe the adder result before the optional output inversion.
module alu_core #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] xp,
  input  logic [WIDTH-1:0] yp,
  input  logic             f,
  input  logic             no,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             cy,
  output logic             ov
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] r;

  always_comb begin
    sum = {1'b0, xp} + {1'b0, yp};
    r   = '0;
    cy  = 1'b0;
    ov  = 1'b0;
    if (f) begin
      r  = sum[WIDTH-1:0];
      cy = sum[WIDTH];
      // Two's-complement overflow: like-signed operands yielding an opposite-signed sum.
      ov = (xp[MSB] == yp[MSB]) && (r[MSB] != xp[MSB]);
    end else begin
      r  = xp & yp;
    end
    out = no ? ~r : r;
    zr  = (out == '0);
    ng  = out[MSB];
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined Hack-style ALU with valid/ready handshake and status flags.
// S1 registers the preset operands, S2 registers the result; one op per cycle, latency 2.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             cy,
  output logic             ov
);

  function automatic logic [WIDTH-1:0] preset(input logic [WIDTH-1:0] v,
                                              input logic             zero,
                                              input logic             neg);
    logic [WIDTH-1:0] t;
    t = zero ? '0 : v;
    return neg ? ~t : t;
  endfunction

  alu_ctrl_t        op;
  logic             s2_free;
  logic             adv;
  logic             acc;

  logic [WIDTH-1:0] xp_p0;
  logic [WIDTH-1:0] yp_p0;

  logic             vld_p1;
  logic [WIDTH-1:0] xp_p1;
  logic [WIDTH-1:0] yp_p1;
  logic             f_p1;
  logic             no_p1;

  logic [WIDTH-1:0] out_c;
  logic             zr_c;
  logic             ng_c;
  logic             cy_c;
  logic             ov_c;

  logic             vld_p2;
  logic [WIDTH-1:0] out_p2;
  logic             zr_p2;
  logic             ng_p2;
  logic             cy_p2;
  logic             ov_p2;

  assign op = alu_ctrl_t'(ctrl);

  // S2 can take a new result when empty or when its current result leaves this cycle.
  assign s2_free  = !vld_p2 || out_ready;
  assign adv      = vld_p1 && s2_free;
  assign in_ready = !vld_p1 || s2_free;
  assign acc      = in_valid && in_ready;

  // ---- P0 -> P1: operand preset (zero / invert) ----
  assign xp_p0 = preset(x, op.zx, op.nx);
  assign yp_p0 = preset(y, op.zy, op.ny);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (acc) begin
      vld_p1 <= 1'b1;
    end else if (adv) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      xp_p1 <= xp_p0;
      yp_p1 <= yp_p0;
      f_p1  <= op.f;
      no_p1 <= op.no;
    end
  end

  // ---- P1 -> P2: function, output inversion and flags ----
  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .xp  (xp_p1),
    .yp  (yp_p1),
    .f   (f_p1),
    .no  (no_p1),
    .out (out_c),
    .zr  (zr_c),
    .ng  (ng_c),
    .cy  (cy_c),
    .ov  (ov_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      out_p2 <= '0;
      zr_p2  <= 1'b0;
      ng_p2  <= 1'b0;
      cy_p2  <= 1'b0;
      ov_p2  <= 1'b0;
    end else if (adv) begin
      vld_p2 <= 1'b1;
      out_p2 <= out_c;
      zr_p2  <= zr_c;
      ng_p2  <= ng_c;
      cy_p2  <= cy_c;
      ov_p2  <= ov_c;
    end else if (out_ready) begin
      vld_p2 <= 1'b0;
    end
  end

  assign out_valid = vld_p2;
  assign out       = out_p2;
  assign zr        = zr_p2;
  assign ng        = ng_p2;
  assign cy        = cy_p2;
  assign ov        = ov_p2;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed scoreboard bench for alu_pipe (WIDTH=16 main instance plus a WIDTH=8 instance).
module tb_alu_pipe;
  import alu_pkg::*;

  typedef struct {
    logic [15:0] out;
    logic        zr;
    logic        ng;
    logic        cy;
    logic        ov;
    int          acc;
    bit          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [15:0] y;
  logic [5:0]  ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        zr, ng, cy, ov;

  logic        in_valid8;
  logic        in_ready8;
  logic [7:0]  x8;
  logic [7:0]  y8;
  logic [5:0]  ctrl8;
  logic        out_valid8;
  logic        out_ready8;
  logic [7:0]  out8;
  logic        zr8, ng8, cy8, ov8;

  int n_assert = 0;
  int n_fail   = 0;
  int n_xfer   = 0;
  int cyc      = 0;
  exp_t sb[$];

  logic        prev_stall = 1'b0;
  logic [15:0] prev_out;
  logic [3:0]  prev_flags;

  alu_ctrl_t   ops [18] = '{ALU_ZERO, ALU_ONE, ALU_NEG1, ALU_X, ALU_Y, ALU_NOTX,
                            ALU_NOTY, ALU_NEGX, ALU_NEGY, ALU_XP1, ALU_YP1, ALU_XM1,
                            ALU_YM1, ALU_XPY, ALU_XMY, ALU_YMX, ALU_XANDY, ALU_XORY};
  logic [15:0] hand [18] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h00FF, 16'h003F, 16'hFF00,
                            16'hFFC0, 16'hFF01, 16'hFFC1, 16'h0100, 16'h0040, 16'h00FE,
                            16'h003E, 16'h013E, 16'h00C0, 16'hFF40, 16'h003F, 16'h00FF};

  alu_pipe #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .ctrl(ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zr(zr), .ng(ng), .cy(cy), .ov(ov)
  );

  alu_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .x(x8), .y(y8), .ctrl(ctrl8), .out_valid(out_valid8), .out_ready(out_ready8),
    .out(out8), .zr(zr8), .ng(ng8), .cy(cy8), .ov(ov8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference Hack ALU; overflow is taken from the true signed sum.
  function automatic exp_t mk(input logic [5:0] c, input logic [15:0] xv, input logic [15:0] yv);
    exp_t        e;
    logic [15:0] a, b, r;
    logic [16:0] s;
    int          sa;
    a = c[5] ? 16'h0000 : xv;
    if (c[4]) a = ~a;
    b = c[3] ? 16'h0000 : yv;
    if (c[2]) b = ~b;
    e.cy = 1'b0;
    e.ov = 1'b0;
    if (c[1]) begin
      s    = {1'b0, a} + {1'b0, b};
      r    = s[15:0];
      e.cy = s[16];
      sa   = int'($signed(a)) + int'($signed(b));
      e.ov = (sa > 32767) || (sa < -32768);
    end else begin
      r = a & b;
    end
    if (c[0]) r = ~r;
    e.out = r;
    e.zr  = (r == 16'h0000);
    e.ng  = r[15];
    e.acc = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  task automatic send(input logic [5:0] c, input logic [15:0] xv, input logic [15:0] yv,
                      input exp_t e, input bit lat);
    bit done = 1'b0;
    in_valid = 1'b1;
    ctrl     = c;
    x        = xv;
    y        = yv;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.acc = cyc;
        e.lat = lat;
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    check("accept_timeout", done, 1'b1);
  endtask

  task automatic drain(input string tag);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check(tag, sb.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_out_stable", out, prev_out);
        check("stall_flags_stable", {zr, ng, cy, ov}, prev_flags);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 1'b1, 1'b0);
        end else begin
          e = sb.pop_front();
          check("out", out, e.out);
          check("zr", zr, e.zr);
          check("ng", ng, e.ng);
          check("cy", cy, e.cy);
          check("ov", ov, e.ov);
          if (e.lat) check("latency", cyc - e.acc, 2);
          n_xfer++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = out;
      prev_flags = {zr, ng, cy, ov};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   base;
    int   c0;
    bit   got;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x = '0; y = '0; ctrl = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; x8 = '0; y8 = '0; ctrl8 = '0;

    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out", out, 16'h0000);
    check("rst_flags", {zr, ng, cy, ov}, 4'b0000);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid8", out_valid8, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // All 18 canonical functions back-to-back with x=255, y=63.
    for (int i = 0; i < 18; i++) begin
      e     = mk(ops[i], 16'd255, 16'd63);
      e.out = hand[i];
      e.zr  = (hand[i] == 16'h0000);
      e.ng  = hand[i][15];
      send(ops[i], 16'd255, 16'd63, e, 1'b1);
    end
    drain("drain_canonical");

    // Carry and signed overflow corners.
    e = '{out: 16'h0000, zr: 1'b1, ng: 1'b0, cy: 1'b1, ov: 1'b0, acc: 0, lat: 1'b0};
    send(ALU_XPY, 16'hFFFF, 16'h0001, e, 1'b1);
    e = '{out: 16'h8000, zr: 1'b0, ng: 1'b1, cy: 1'b0, ov: 1'b1, acc: 0, lat: 1'b0};
    send(ALU_XPY, 16'h7FFF, 16'h0001, e, 1'b1);
    drain("drain_carry");

    // Backpressure: two ops fill the pipe, the third waits for out_ready.
    base = n_xfer;
    out_ready = 1'b0;
    send(ALU_X, 16'h1111, 16'h0000, mk(ALU_X, 16'h1111, 16'h0000), 1'b0);
    send(ALU_Y, 16'h0000, 16'h2222, mk(ALU_Y, 16'h0000, 16'h2222), 1'b0);
    in_valid = 1'b1; ctrl = ALU_XPY; x = 16'h1000; y = 16'h0234;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_op1_presented", out, 16'h1111);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(ALU_XPY, 16'h1000, 16'h0234, mk(ALU_XPY, 16'h1000, 16'h0234), 1'b0);
    drain("drain_backpressure");
    check("bp_transfers", n_xfer - base, 3);

    // Bubbles: in_valid toggles every cycle.
    base = n_xfer;
    for (int i = 0; i < 4; i++) begin
      send(ALU_XMY, 16'(100 * i + 7), 16'(3 * i), mk(ALU_XMY, 16'(100 * i + 7), 16'(3 * i)), 1'b1);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    drain("drain_bubbles");
    check("bubble_transfers", n_xfer - base, 4);

    // Asynchronous reset with both stages occupied.
    out_ready = 1'b0;
    send(ALU_NEG1, 16'h0000, 16'h0000, mk(ALU_NEG1, 16'h0000, 16'h0000), 1'b0);
    send(ALU_XPY, 16'hFFFF, 16'h0001, mk(ALU_XPY, 16'hFFFF, 16'h0001), 1'b0);
    in_valid = 1'b0;
    #2;
    check("pre_rst_out_valid", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", out_valid, 1'b0);
    check("async_rst_out", out, 16'h0000);
    check("async_rst_flags", {zr, ng, cy, ov}, 4'b0000);
    check("async_rst_in_ready", in_ready, 1'b1);
    sb.delete();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_empty", out_valid, 1'b0);
    base = n_xfer;
    send(ALU_XPY, 16'h0102, 16'h0304, mk(ALU_XPY, 16'h0102, 16'h0304), 1'b1);
    drain("drain_post_reset");
    check("post_rst_transfers", n_xfer - base, 1);

    // WIDTH=8: 0x80 + 0x80.
    in_valid8 = 1'b1; ctrl8 = ALU_XPY; x8 = 8'h80; y8 = 8'h80;
    @(negedge clk);
    check("w8_in_ready", in_ready8, 1'b1);
    c0 = cyc;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (out_valid8) begin
        got = 1'b1;
        check("w8_latency", cyc - c0, 2);
        check("w8_out", out8, 8'h00);
        check("w8_zr", zr8, 1'b1);
        check("w8_ng", ng8, 1'b0);
        check("w8_cy", cy8, 1'b1);
        check("w8_ov", ov8, 1'b1);
      end
    end
    check("w8_output_seen", got, 1'b1);

    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
